// File: rtl/prescale_pkg.sv
// Shared constants for the prescaler: default width and phase-flag encoding.
package prescale_pkg;
  localparam int   PRESCALE_WIDTH_DEFAULT = 8;
  localparam logic PH_HIGH = 1'b0;
  localparam logic PH_LOW  = 1'b1;
endpackage

// File: rtl/prescale_param.sv
// Two-phase programmable prescaler emitting a one-cycle tick per (H+1)+(L+1) period.
// Define PRESCALE_SHADOW_EN to latch high/low into shadows so changes apply per period.
module prescale_param
  import prescale_pkg::*;
#(
  parameter int WIDTH = PRESCALE_WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] high,
  input  logic [WIDTH-1:0] low,
  input  logic             enable,
  input  logic             sync_rst,
  output logic             Prescale_EN,
  output logic             phase_lo,
  output logic [WIDTH-1:0] tick_cnt
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] tc_q, tc_d;
  logic             ph_q, ph_d;
  logic             en_q, en_d;
  logic [WIDTH-1:0] h_eff, l_eff;
  logic             period_end;

`ifdef PRESCALE_SHADOW_EN
  logic [WIDTH-1:0] hs_q, ls_q;
  logic             shadow_ld;
  assign h_eff     = hs_q;
  assign l_eff     = ls_q;
  assign shadow_ld = sync_rst | ~enable | period_end;
`else
  assign h_eff = high;
  assign l_eff = low;
`endif

  // >= so a live shrink of high/low terminates the phase instead of wrapping
  assign period_end = enable & (ph_q == PH_LOW) & (lo_q >= l_eff);

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    tc_d = tc_q;
    ph_d = ph_q;
    en_d = 1'b0;
    if (sync_rst) begin
      hi_d = '0;
      lo_d = '0;
      tc_d = '0;
      ph_d = PH_HIGH;
    end else if (enable) begin
      if (ph_q == PH_HIGH) begin
        if (hi_q >= h_eff) begin
          hi_d = '0;
          ph_d = PH_LOW;
        end else begin
          hi_d = hi_q + ONE;
        end
      end else if (period_end) begin
        lo_d = '0;
        ph_d = PH_HIGH;
        en_d = 1'b1;
        tc_d = tc_q + ONE;
      end else begin
        lo_d = lo_q + ONE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
      tc_q <= '0;
      ph_q <= PH_HIGH;
      en_q <= 1'b0;
`ifdef PRESCALE_SHADOW_EN
      hs_q <= '0;
      ls_q <= '0;
`endif
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      tc_q <= tc_d;
      ph_q <= ph_d;
      en_q <= en_d;
`ifdef PRESCALE_SHADOW_EN
      if (shadow_ld) begin
        hs_q <= high;
        ls_q <= low;
      end
`endif
    end
  end

  assign Prescale_EN = en_q;
  assign phase_lo    = ph_q;
  assign tick_cnt    = tc_q;

endmodule

// File: doc/prescale_param.md
PRESCALE_PARAM -- requirements
Module: prescale_param

Interface
REQ-001 WIDTH, 8, counter/register width in bits; legal range 2..16.
REQ-002 clock  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 high  input  WIDTH  high-phase length minus one, in clock cycles.
REQ-005 low  input  WIDTH  low-phase length minus one, in clock cycles.
REQ-006 enable  input  1  run control; 0 freezes counting.
REQ-007 sync_rst  input  1  synchronous restart of the period, e.g. on a CAN hard-sync edge.
REQ-008 Prescale_EN  output  1  registered one-cycle tick at each period end.
REQ-009 phase_lo  output  1  registered phase flag: 0 = high phase, 1 = low phase.
REQ-010 tick_cnt  output  WIDTH  registered count of ticks issued since reset or restart; wraps modulo 2^WIDTH.

Function
REQ-011 Period SHALL be (H+1)+(L+1) cycles, where H and L are the effective high and low values.
REQ-012 High phase: hi_count SHALL step 0..H; on the edge where hi_count >= H, hi_count SHALL clear and phase_lo SHALL go to 1.
REQ-013 Low phase: lo_count SHALL step 0..L; on the edge where lo_count >= L, lo_count SHALL clear, phase_lo SHALL go to 0, Prescale_EN SHALL go to 1 for exactly one cycle, and tick_cnt SHALL increment.
REQ-014 Compares SHALL use >= rather than ==, so a live decrease of high/low mid-phase ends the phase on the next edge instead of wrapping through 2^WIDTH.
REQ-015 With high=low=0, Prescale_EN SHALL pulse every 2nd cycle.
REQ-016 On an edge with enable=0 and sync_rst=0, all counters and phase_lo SHALL hold and Prescale_EN SHALL be 0.
REQ-017 On an edge with sync_rst=1, regardless of enable: hi_count, lo_count and tick_cnt SHALL clear, phase_lo SHALL go to 0, and Prescale_EN SHALL be 0.
REQ-018 If sync_rst coincides with a period end, sync_rst SHALL win and no tick SHALL be emitted.
REQ-019 Prescale_EN SHALL never be high in two consecutive cycles.
REQ-020 When sync_rst goes 0 with enable=1, the first tick SHALL follow (H+1)+(L+1) edges later.

Reset
REQ-021 On reset=0, asynchronously: hi_count=0, lo_count=0, phase_lo=0, Prescale_EN=0, tick_cnt=0, shadow registers=0.
REQ-022 After reset release with enable=1, there is no shadow load and high/low are static; the first Prescale_EN SHALL appear after the (high+low+2)-th rising edge.

Configuration
REQ-023 Macro PRESCALE_SHADOW_EN defined: H and L SHALL come from shadow registers.
REQ-024 With PRESCALE_SHADOW_EN, the shadows SHALL load from high/low on any edge with enable=0, with sync_rst=1, or at a period end.
REQ-025 With PRESCALE_SHADOW_EN, a mid-period change of high/low SHALL only take effect from the next period.
REQ-026 Macro undefined: H and L SHALL be the live high/low inputs, no shadow flops SHALL exist, and REQ-014 governs live changes.

Structure
REQ-027 Shared package prescale_pkg SHALL hold PRESCALE_WIDTH_DEFAULT (8) and the phase encoding constants PH_HIGH=0 and PH_LOW=1.
REQ-028 No sub-module is required; counters, phase flag and shadows SHALL be implemented inline in one clocked process.

Verification
REQ-029 Basic timing: reset, enable=1, high=3, low=2 -> Prescale_EN pulses on the edge 7 cycles after reset release, then every 7 cycles; phase_lo is 1 for 3 cycles per period.
REQ-030 Minimum period: high=0, low=0 -> Prescale_EN alternates 1,0,1,0; tick_cnt increments every 2 cycles and wraps 255->0 at WIDTH=8.
REQ-031 Freeze: enable dropped for 5 cycles mid-high-phase -> period stretches by exactly 5 cycles; no tick while frozen.
REQ-032 Restart priority: sync_rst pulsed on a period-end edge -> no tick, tick_cnt=0, next tick (H+L+2) edges after sync_rst falls.
REQ-033 Live change: high changed 9->2 while hi_count=5, macro undefined -> high phase ends next edge; macro defined -> current period keeps 10 high cycles and the next uses 3.
REQ-034 Async reset asserted mid-low-phase, between clock edges -> all outputs 0 immediately without a clock edge.
